bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double dabble (shift right,
//  subtract 3 from any digit >= 8). It is the decode counterpart of the
//  binary-to-BCD converter: it takes packed BCD digits (e.g. keypad or display
//  values) back to straight binary for arithmetic. One shift/correct iteration
//  runs per clock, under a start/busy/done handshake.
// PARAMETERS
//  NDIGITS  3   number of packed BCD digits on the input
//  BIN_W    10  binary result width; must satisfy 2**BIN_W >= 10**NDIGITS
// PORTS
//  clk       in   1          rising-edge clock
//  reset     in   1          asynchronous, active-low reset
//  start     in   1          request a conversion; sampled only when busy=0
//  bcd_data  in   4*NDIGITS  packed BCD, digit 0 in [3:0]; sampled with start
//  busy      out  1          conversion in progress; start is ignored while high
//  done      out  1          one-cycle pulse: bin_data/err updated this cycle
//  bin_data  out  BIN_W      binary result; held until the next done
//  err       out  1          last request had a digit > 9; held until the next done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, busy=0, done=0, bin_data=0, err=0,
//   internal shift regs=0, iteration counter=0. Reset mid-conversion aborts it.
//   No done is produced for the aborted request.
//  States: IDLE, CONV.
//  IDLE, start=1 at edge k:
//   - all digits valid: load bcd_sr<=bcd_data, bin_sr<=0, cnt<=0, state<=CONV,
//     busy<=1.
//   - any digit > 9: stay IDLE, done<=1, err<=1, bin_data<=0. Latency 1 edge.
//  CONV, every edge (edges k+1 .. k+BIN_W):
//   - {bcd_sr,bin_sr} shifted right 1; bcd_sr[0] enters bin_sr[BIN_W-1].
//   - Then every 4-bit digit of the shifted bcd_sr >= 8 has 3 subtracted,
//     combinationally in the same cycle; digits are corrected independently.
//   - cnt increments; on the edge where cnt==BIN_W-1 (the BIN_W-th shift):
//     bin_data<=shifted bin_sr, err<=0, done<=1, busy<=0, state<=IDLE.
//  Latency: start sampled at edge k -> done high after edge k+BIN_W.
//   Throughput is one conversion per BIN_W+1 cycles.
//  done is high for exactly one cycle; it is 0 in every other cycle.
//  busy=0 in the done cycle, so start in that cycle is accepted (back-to-back).
//  start while busy=1: ignored and not queued; the running conversion is
//   unaffected.
//  bcd_data is don't-care except at the accepting edge (captured internally).
//  After BIN_W shifts bcd_sr must be 0 for any valid input (verification
//   assertion). No digit ever underflows: a correction applies only to digits >= 8.
//  Arithmetic: digit correction is 4-bit unsigned; bin_sr is BIN_W bits,
//   no overflow given the BIN_W rule.
// TESTING
//  1 bcd_data=12'h999, start 1 cycle -> done exactly 10 cycles later,
//    bin_data=10'd999, err=0, busy high for 10 cycles.
//  2 12'h000 -> bin_data=0; 12'h255 -> 10'd255; 12'h100 -> 10'd100.
//  3 12'h9A5 (digit 1 = 0xA) -> done next cycle, err=1, bin_data=0, busy never 1;
//    then 12'h042 -> err=0, bin_data=10'd42.
//  4 start=1 with 12'h123 while busy (other value in flight) -> ignored; result
//    is the first value; start re-asserted in the done cycle -> accepted,
//    10'd123 after 10 more cycles.
//  5 reset low at cycle 5 of a conversion of 12'h777 -> all outputs 0
//    immediately (async), no done; after release, 12'h777 -> 10'd777.
//  6 Exhaustive sweep 000..999 against a reference model; also
//    NDIGITS=4, BIN_W=14: 16'h9999 -> 14'd9999.

Source files
------------

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential BCD-to-binary converter (reverse double dabble)
// One shift/correct step per clock under a start/busy/done handshake.
module bcd_to_binary #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_data,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_W-1:0]       bin_data,
    output logic                   err
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [BIN_W-1:0]   bin_q;
    logic               err_q;
    logic [BCD_W-1:0]   bcd_sr_q;
    logic [BIN_W-1:0]   bin_sr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_sr_d;
    logic [BIN_W-1:0]   bin_sr_d;
    logic               bad_digit;
    logic               last_step;

    // Shift the joint register right, then pull every digit >= 8 back by 3.
    always_comb begin
        bcd_shift = {1'b0, bcd_sr_q[BCD_W-1:1]};
        bin_sr_d  = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};
        bcd_sr_d  = bcd_shift;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_sr_d[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_data[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            bin_q  <= '0;
                        end else begin
                            bcd_sr_q <= bcd_data;
                            bin_sr_q <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_sr_q <= bcd_sr_d;
                    bin_sr_q <= bin_sr_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_step) begin
                        bin_q   <= bin_sr_d;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Every BCD bit has migrated into bin_sr by the final shift.
    always @(posedge clk) begin
        if (reset && state_q == CONV && last_step) begin
            assert (bcd_sr_d == '0);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bin_data = bin_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - self-checking bench for bcd_to_binary
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bcd_data = '0;
    logic        busy, done, err;
    logic [9:0]  bin_data;

    logic        start4 = 1'b0;
    logic [15:0] bcd4 = '0;
    logic        busy4, done4, err4;
    logic [13:0] bin4;

    int total = 0;
    int bad = 0;

    logic [10:0] q3[$];
    logic [14:0] q4[$];

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        e;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    bcd_to_binary #(.NDIGITS(3), .BIN_W(10)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bcd_data(bcd_data),
        .busy(busy), .done(done), .bin_data(bin_data), .err(err)
    );

    bcd_to_binary #(.NDIGITS(4), .BIN_W(14)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .bcd_data(bcd4),
        .busy(busy4), .done(done4), .bin_data(bin4), .err(err4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (done) begin
            if (q3.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("bin_data", 32'(bin_data), 32'(e[9:0]));
                chk("err", 32'(err), 32'(e[10]));
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        if (done4) begin
            if (q4.size() == 0) begin
                chk("unexpected_done4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("bin4", 32'(bin4), 32'(e[13:0]));
                chk("err4", 32'(err4), 32'(e[14]));
            end
        end
    end

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end while (!done && n < 40);
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic conv(input logic [11:0] b, input logic [9:0] eb, input logic ee);
        int n, bc;
        @(posedge clk); #1;
        start = 1'b1;
        bcd_data = b;
        q3.push_back({ee, eb});
        @(posedge clk); #1;
        start = 1'b0;
        bcd_data = 12'($urandom);
        wait_done(n, bc);
        chk("latency", n, ee ? 1 : 11);
        chk("busy_cycles", bc, ee ? 0 : 10);
    endtask

    task automatic conv4(input logic [15:0] b, input logic [13:0] eb, input logic ee);
        int n;
        @(posedge clk); #1;
        start4 = 1'b1;
        bcd4 = b;
        q4.push_back({ee, eb});
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 40);
        chk("latency4", n, ee ? 1 : 15);
    endtask

    initial begin
        int n, bc, dcnt;
        logic [11:0] b;

        vecs[0] = '{12'h999, 10'd999, 1'b0};
        vecs[1] = '{12'h000, 10'd0,   1'b0};
        vecs[2] = '{12'h255, 10'd255, 1'b0};
        vecs[3] = '{12'h100, 10'd100, 1'b0};
        vecs[4] = '{12'h9A5, 10'd0,   1'b1};
        vecs[5] = '{12'h042, 10'd42,  1'b0};
        vecs[6] = '{12'hF00, 10'd0,   1'b1};
        vecs[7] = '{12'h00B, 10'd0,   1'b1};
        vecs[8] = '{12'h808, 10'd808, 1'b0};
        vecs[9] = '{12'h001, 10'd1,   1'b0};

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bin", 32'(bin_data), 0);
        chk("rst_err", 32'(err), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            conv(vecs[i].bcd, vecs[i].bin, vecs[i].e);
        end

        // start held while busy, then still high in the done cycle
        @(posedge clk); #1;
        start = 1'b1;
        bcd_data = 12'h456;
        q3.push_back({1'b0, 10'd456});
        q3.push_back({1'b0, 10'd123});
        @(posedge clk); #1;
        bcd_data = 12'h123;
        wait_done(n, bc);
        chk("busy_ignore_latency", n, 11);
        @(posedge clk); #1;
        start = 1'b0;
        bcd_data = 12'h000;
        wait_done(n, bc);
        chk("b2b_latency", n, 11);

        // reset aborting a conversion of 777
        @(posedge clk); #1;
        start = 1'b1;
        bcd_data = 12'h777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_bin", 32'(bin_data), 0);
        chk("abort_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        conv(12'h777, 10'd777, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            conv(b, 10'(i), 1'b0);
        end

        conv4(16'h9999, 14'd9999, 1'b0);
        conv4(16'h0000, 14'd0,    1'b0);
        conv4(16'h1234, 14'd1234, 1'b0);
        conv4(16'h0A00, 14'd0,    1'b1);
        conv4(16'h5008, 14'd5008, 1'b0);

        repeat (3) @(negedge clk);
        chk("q3_drained", q3.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
